// File: rtl/hq_pkg.sv
// Shared types and constants for the H x Q scheduler.
// Latency: n/a (package only).
// Backpressure: n/a.
package hq_pkg;

    localparam int MAT_DIM     = 4;   // H is MAT_DIM x MAT_DIM
    localparam int H_ELEMS     = 16;  // elements loaded per H matrix
    localparam int OUT_PER_MAT = 8;   // multiplier results per Q matrix
    localparam int NUM_Q       = 16;  // Q matrices per run

    localparam int IDX_W = $clog2(OUT_PER_MAT);
    localparam int Q_W   = $clog2(NUM_Q);
    localparam int RC_W  = $clog2(MAT_DIM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } hq_state_e;

endpackage

// File: rtl/hq_out_fifo.sv
// Registered output FIFO with drop-on-full reporting.
// Latency: a push is visible on out_vld the cycle after it is written.
// Backpressure: none upstream; a push into a full FIFO without a same-cycle pop is dropped and flagged.
// Ports: clk/rst_n; push_vld/push_dat (write side), drop (push lost);
//        out_vld/out_rdy/out_dat (read side, data zero while empty).
module hq_out_fifo #(
    parameter int W     = 39,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    output logic         drop,
    output logic         out_vld,
    input  logic         out_rdy,
    output logic [W-1:0] out_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   cnt_q;
    logic          empty, full, do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    // Pop only what exists, so push+pop on empty degenerates to a push.
    assign do_pop  = out_rdy && !empty;
    // A pop in the same cycle frees the slot a full-FIFO push needs.
    assign do_push = push_vld && (!full || do_pop);
    assign drop    = push_vld && !do_push;

    assign out_vld = !empty;
    // Gate with empty so the read data is zero out of reset.
    assign out_dat = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through the counter.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/hq_sched.sv
// Scheduler: loads a 4x4 H matrix, feeds it to the multiplier, tags and queues its results.
// Latency: mm_h_* is combinational from mm_i_cnt/mm_k_cnt; results reach out_* one cycle after mm_hq_valid.
// Backpressure: out_ready stalls the output FIFO; results arriving while it is full are dropped and ovf is set.
// Ports: h_in_* (H load stream), mm_* (multiplier control/status/results),
//        out_* (tagged result stream), busy/done/ovf status.
// Optional: define HQ_SCHED_OVF_CNT_EN to add ovf_cnt, a saturating count of dropped results.
module hq_sched
    import hq_pkg::*;
#(
    parameter int N          = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                h_in_valid,
    output logic                h_in_ready,
    input  logic signed [N-1:0] h_in_r,
    input  logic signed [N-1:0] h_in_i,
    output logic                mm_start,
    output logic signed [N-1:0] mm_h_r,
    output logic signed [N-1:0] mm_h_i,
    input  logic [RC_W-1:0]     mm_i_cnt,
    input  logic [RC_W-1:0]     mm_k_cnt,
    input  logic                mm_hq_valid,
    input  logic                mm_one_done,
    input  logic                mm_all_done,
    input  logic signed [N-1:0] mm_hq_r,
    input  logic signed [N-1:0] mm_hq_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [N-1:0] out_r,
    output logic signed [N-1:0] out_i,
    output logic [Q_W-1:0]      out_q,
    output logic [IDX_W-1:0]    out_idx,
    output logic                busy,
    output logic                done,
    output logic                ovf
`ifdef HQ_SCHED_OVF_CNT_EN
    ,
    output logic [7:0]          ovf_cnt
`endif
);
    localparam int EW = $clog2(H_ELEMS);
    localparam int FW = 2*N + Q_W + IDX_W;

    hq_state_e        state_q, state_d;
    logic [2*N-1:0]   hbuf_q [H_ELEMS];
    logic [EW-1:0]    ld_cnt_q, ld_cnt_d, wr_idx;
    logic [Q_W-1:0]   q_tag_q, q_tag_d;
    logic [IDX_W-1:0] idx_tag_q, idx_tag_d;
    logic             ovf_q, ovf_d;
    logic             load_entry, push, drop;
    logic [FW-1:0]    fifo_out;

    // The first beat is taken in IDLE; that same edge starts a new operation.
    assign load_entry = (state_q == ST_IDLE) && h_in_valid;
    assign push       = (state_q == ST_RUN) && mm_hq_valid;
    assign wr_idx     = (state_q == ST_IDLE) ? '0 : ld_cnt_q;

    always_comb begin
        state_d    = state_q;
        ld_cnt_d   = ld_cnt_q;
        q_tag_d    = q_tag_q;
        idx_tag_d  = idx_tag_q;
        h_in_ready = 1'b0;
        mm_start   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                h_in_ready = 1'b1;
                if (h_in_valid) begin
                    state_d   = ST_LOAD;
                    ld_cnt_d  = EW'(1);
                    q_tag_d   = '0;
                    idx_tag_d = '0;
                end
            end
            ST_LOAD: begin
                h_in_ready = 1'b1;
                busy       = 1'b1;
                if (h_in_valid) begin
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_cnt_q == EW'(H_ELEMS-1)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                mm_start = 1'b1;
                // one_done closes the matrix even if fewer than 8 results came.
                if (mm_one_done) begin
                    idx_tag_d = '0;
                    q_tag_d   = q_tag_q + 1'b1;
                end else if (mm_hq_valid) begin
                    idx_tag_d = idx_tag_q + 1'b1;
                end
                if (mm_all_done) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!out_valid) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ovf_d = load_entry ? 1'b0 : (ovf_q | drop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ld_cnt_q  <= '0;
            q_tag_q   <= '0;
            idx_tag_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            q_tag_q   <= q_tag_d;
            idx_tag_q <= idx_tag_d;
            ovf_q     <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (h_in_valid && h_in_ready) hbuf_q[wr_idx] <= {h_in_r, h_in_i};
    end

    // Row-major: element (i,k) lives at i*MAT_DIM + k.
    assign {mm_h_r, mm_h_i} = hbuf_q[{mm_i_cnt, mm_k_cnt}];
    assign ovf              = ovf_q;

`ifdef HQ_SCHED_OVF_CNT_EN
    logic [7:0] ovf_cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ovf_cnt_q <= '0;
        else if (load_entry)                 ovf_cnt_q <= '0;
        else if (drop && ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
    end
    assign ovf_cnt = ovf_cnt_q;
`endif

    hq_out_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_vld (push),
        .push_dat ({mm_hq_r, mm_hq_i, q_tag_q, idx_tag_q}),
        .drop     (drop),
        .out_vld  (out_valid),
        .out_rdy  (out_ready),
        .out_dat  (fifo_out)
    );

    assign {out_r, out_i, out_q, out_idx} = fifo_out;

endmodule

// File: doc/hq_sched.md
HQ_SCHED -- requirements
Module: hq_sched

Interface
REQ-001 SHALL have parameter N, default 16, sample width in bits for real and imaginary parts.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, output FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports h_in_valid (input, 1), h_in_ready (output, 1), h_in_r and h_in_i (input, N, signed): H load stream, row-major, 16 elements.
REQ-006 SHALL have ports mm_start (output, 1), mm_h_r and mm_h_i (output, N, signed): drive the multiplier.
REQ-007 SHALL have ports mm_i_cnt and mm_k_cnt (input, 2), mm_hq_valid, mm_one_done and mm_all_done (input, 1), mm_hq_r and mm_hq_i (input, N): multiplier status and results.
REQ-008 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_r and out_i (output, N), out_q (output, 4), out_idx (output, 3): tagged result stream.
REQ-009 SHALL have ports busy, done and ovf (output, 1 each).

Function
REQ-010 SHALL implement FSM IDLE, LOAD, RUN, DRAIN, DONE.
REQ-011 IDLE: h_in_ready=1; the first h_in_valid SHALL be accepted into hbuf[0][0] and move the FSM to LOAD.
REQ-012 LOAD: h_in_ready=1; each valid&ready beat SHALL write hbuf[row][col] with col incrementing first; acceptance of the 16th element SHALL move the FSM to RUN.
REQ-013 h_in_ready SHALL be 0 in RUN, DRAIN and DONE.
REQ-014 mm_start SHALL be 1 for every cycle in RUN and 0 in all other states.
REQ-015 mm_h_r and mm_h_i SHALL be combinational hbuf[mm_i_cnt][mm_k_cnt], with zero added latency.
REQ-016 On each mm_hq_valid, {mm_hq_r, mm_hq_i, q_tag, idx_tag} SHALL be pushed into the output FIFO; idx_tag counts 0..7 per matrix and q_tag counts 0..15.
REQ-017 idx_tag SHALL wrap to 0 and q_tag SHALL increment on mm_one_done; mm_one_done with idx_tag!=7 SHALL still force the wrap.
REQ-018 mm_all_done in RUN SHALL move the FSM to DRAIN.
REQ-019 DRAIN SHALL hold until the FIFO is empty, then move to DONE.
REQ-020 DONE SHALL last exactly one cycle, with done=1, then move to IDLE.
REQ-021 busy SHALL be 1 in LOAD, RUN and DRAIN.
REQ-022 out_valid SHALL equal FIFO not-empty; a beat transfers when out_valid&out_ready; data SHALL be held stable while stalled.
REQ-023 The FIFO SHALL be registered: a push SHALL be visible on out_valid no earlier than the next cycle.
REQ-024 A push when full SHALL be accepted if a pop occurs the same cycle; otherwise the sample SHALL be dropped, ovf set sticky, and counters still advanced.
REQ-025 Simultaneous push and pop on an empty FIFO SHALL be a push only.
REQ-026 ovf SHALL clear only on reset or on entry to LOAD.
REQ-027 mm_hq_valid outside RUN SHALL be ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force: IDLE, mm_start=0, FIFO empty, out_valid=0, out_r=out_i=0, out_q=0, out_idx=0, done=0, busy=0, ovf=0, all tags/counters 0; hbuf content SHALL be don't-care.
REQ-029 Reset mid-RUN SHALL abort the operation; no FIFO entries SHALL survive.

Configuration
REQ-030 With macro HQ_SCHED_OVF_CNT_EN defined, an extra output ovf_cnt (8 bits, saturating at 255) SHALL count dropped samples and clear with ovf; without it the port SHALL be absent and ovf behaviour SHALL be unchanged.

Structure
REQ-031 Package hq_pkg SHALL hold the FSM state typedef and constants MAT_DIM=4, H_ELEMS=16, OUT_PER_MAT=8, NUM_Q=16.
REQ-032 The output FIFO SHALL be sub-module hq_out_fifo, parameterised by width and FIFO_DEPTH.

Verification
REQ-033 Load H with hbuf[r][c]=16*r+c (imag 0), out_ready=1 -> 128 outputs tagged q 0..15, idx 0..7 in order; done pulses once; ovf=0.
REQ-034 Force mm_i_cnt=2, mm_k_cnt=3 during RUN -> mm_h_r=35 in the same cycle.
REQ-035 out_ready=0 throughout RUN -> FIFO holds 8 entries, ovf=1 from the 9th sample; ovf_cnt=120 with the macro defined.
REQ-036 FIFO full while out_ready=1 on a push cycle -> no drop, ovf stays 0.
REQ-037 Assert rst_n low at the 5th result of q=3 -> all outputs are at reset values immediately; a fresh load restarts at q=0, idx=0.
REQ-038 h_in_valid toggling 1/0 during LOAD -> exactly 16 accepted beats, then RUN; h_in_ready=0 after the 16th beat.
